// File: rtl/vga_frame_transmitter_pkg.sv
// vga_frame_transmitter_pkg: VGA 640x480@60 timing defaults, pipeline stage type and sync helpers
package vga_frame_transmitter_pkg;
  localparam int VGA_HACT = 640;
  localparam int VGA_HFP = 16;
  localparam int VGA_HSW = 96;
  localparam int VGA_HBP = 48;
  localparam int VGA_VACT = 480;
  localparam int VGA_VFP = 10;
  localparam int VGA_VSH = 2;
  localparam int VGA_VBP = 33;
  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
    logic fs;
  } stage_t;
  function automatic int line_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction
  function automatic logic sync_level(input logic active, input bit active_low);
    return active ^ active_low;
  endfunction
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: raster h/v counters with wrap and active/sync region decode
module vga_timing_counter import vga_frame_transmitter_pkg::*; #(
  parameter int HACT = VGA_HACT,
  parameter int HFP = VGA_HFP,
  parameter int HSW = VGA_HSW,
  parameter int HBP = VGA_HBP,
  parameter int VACT = VGA_VACT,
  parameter int VFP = VGA_VFP,
  parameter int VSH = VGA_VSH,
  parameter int VBP = VGA_VBP,
  parameter int H_TOTAL = line_total(HACT, HFP, HSW, HBP),
  parameter int V_TOTAL = line_total(VACT, VFP, VSH, VBP),
  parameter int HW = $clog2(H_TOTAL),
  parameter int VW = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tick_i,
  input  logic          adv_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o
);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic h_end, v_end;
  // next raster position: advance with wrap, or park at the origin when not running
  always_comb begin
    h_end = h_q == HW'(H_TOTAL - 1);
    v_end = v_q == VW'(V_TOTAL - 1);
    h_d = (!adv_i || h_end) ? '0 : h_q + HW'(1);
    v_d = (!adv_i || (h_end && v_end)) ? '0 : v_q + VW'(h_end);
  end
  // raster position register; holds between pixel ticks
  always_ff @(posedge clk_i)
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else if (tick_i) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  assign h_o = h_q;
  assign v_o = v_q;
  assign active_o = (h_q < HW'(HACT)) && (v_q < VW'(VACT));
  assign hsync_o = (h_q >= HW'(HACT + HFP)) && (h_q < HW'(HACT + HFP + HSW));
  assign vsync_o = (v_q >= VW'(VACT + VFP)) && (v_q < VW'(VACT + VFP + VSH));
endmodule

// File: rtl/vga_frame_transmitter.sv
// vga_frame_transmitter: VGA raster source fetching pixels over a request port, 2-tick output pipeline
module vga_frame_transmitter import vga_frame_transmitter_pkg::*; #(
  parameter int P_PIXEL_DEPTH = 24,
  parameter int P_HACT = VGA_HACT,
  parameter int P_HFP = VGA_HFP,
  parameter int P_HSW = VGA_HSW,
  parameter int P_HBP = VGA_HBP,
  parameter int P_VACT = VGA_VACT,
  parameter int P_VFP = VGA_VFP,
  parameter int P_VSH = VGA_VSH,
  parameter int P_VBP = VGA_VBP,
  parameter bit P_SYNC_ACTIVE_LOW = 1'b1,
  parameter int P_COLUMN_BITS = $clog2(P_HACT),
  parameter int P_ROW_BITS = $clog2(P_VACT)
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_PIXEL_CLK_EN,
  input  logic                     I_ENABLE,
  output logic                     O_PIXEL_REQUEST,
  output logic [P_COLUMN_BITS-1:0] O_REQUEST_COLUMN,
  output logic [P_ROW_BITS-1:0]    O_REQUEST_ROW,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
  output logic [P_PIXEL_DEPTH-1:0] O_PIXEL,
  output logic                     O_DATA_VALID,
  output logic                     O_HSYNC,
  output logic                     O_VSYNC,
  output logic                     O_FRAME_START
);
  localparam int HW = $clog2(line_total(P_HACT, P_HFP, P_HSW, P_HBP));
  localparam int VW = $clog2(line_total(P_VACT, P_VFP, P_VSH, P_VBP));
  logic run_q, req, active, hsync, vsync;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  stage_t s1_q, s1_d, s2_q, s2_d;
  logic [P_PIXEL_DEPTH-1:0] pix_q, pix_d;
  vga_timing_counter #(
    .HACT(P_HACT), .HFP(P_HFP), .HSW(P_HSW), .HBP(P_HBP),
    .VACT(P_VACT), .VFP(P_VFP), .VSH(P_VSH), .VBP(P_VBP)
  ) u_timing (
    .clk_i(I_CLK),
    .rst_i(I_RESET),
    .tick_i(I_PIXEL_CLK_EN),
    .adv_i(I_ENABLE && run_q),
    .h_o(h),
    .v_o(v),
    .active_o(active),
    .hsync_o(hsync),
    .vsync_o(vsync)
  );
  // fetch request for the current position and next pipeline contents; stopping flushes both stages
  always_comb begin
    req = run_q && active;
    O_PIXEL_REQUEST = req;
    O_REQUEST_COLUMN = req ? h[P_COLUMN_BITS-1:0] : '0;
    O_REQUEST_ROW = req ? v[P_ROW_BITS-1:0] : '0;
    s1_d = '{dv: req, hs: run_q && hsync, vs: run_q && vsync, fs: req && h == '0 && v == '0};
    s2_d = run_q ? s1_q : '0;
    pix_d = (run_q && s1_q.dv) ? I_PIXEL : '0;
  end
  // run state and both output stages; only pixel ticks advance them, reset wins regardless
  always_ff @(posedge I_CLK)
    if (I_RESET) begin
      run_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      pix_q <= '0;
    end else if (I_PIXEL_CLK_EN) begin
      run_q <= I_ENABLE;
      s1_q <= s1_d;
      s2_q <= s2_d;
      pix_q <= pix_d;
    end
  assign O_PIXEL = pix_q;
  assign O_DATA_VALID = s2_q.dv;
  assign O_HSYNC = sync_level(s2_q.hs, P_SYNC_ACTIVE_LOW);
  assign O_VSYNC = sync_level(s2_q.vs, P_SYNC_ACTIVE_LOW);
  assign O_FRAME_START = s2_q.fs;
endmodule

// File: tb/tb_vga_frame_transmitter.sv
// tb_vga_frame_transmitter: directed and random stimulus against a raster-position reference model
module tb_vga_frame_transmitter;
  logic I_CLK = 1'b0, I_RESET = 1'b1, I_PIXEL_CLK_EN = 1'b0, I_ENABLE = 1'b0;
  logic [23:0] I_PIXEL = '0;
  logic O_PIXEL_REQUEST, O_DATA_VALID, O_HSYNC, O_VSYNC, O_FRAME_START;
  logic [1:0] O_REQUEST_COLUMN, O_REQUEST_ROW;
  logic [23:0] O_PIXEL;
  int errors = 0, checks = 0;
  bit r0, r1, r2;
  int p0, p1, p2;
  vga_frame_transmitter #(
    .P_PIXEL_DEPTH(24), .P_HACT(4), .P_HFP(1), .P_HSW(2), .P_HBP(1),
    .P_VACT(3), .P_VFP(1), .P_VSH(1), .P_VBP(1), .P_SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_PIXEL_CLK_EN(I_PIXEL_CLK_EN), .I_ENABLE(I_ENABLE),
    .O_PIXEL_REQUEST(O_PIXEL_REQUEST), .O_REQUEST_COLUMN(O_REQUEST_COLUMN),
    .O_REQUEST_ROW(O_REQUEST_ROW), .I_PIXEL(I_PIXEL), .O_PIXEL(O_PIXEL),
    .O_DATA_VALID(O_DATA_VALID), .O_HSYNC(O_HSYNC), .O_VSYNC(O_VSYNC), .O_FRAME_START(O_FRAME_START)
  );
  always #5 I_CLK = ~I_CLK;
  function automatic logic [23:0] pat(input int p);
    return {4'hA, 8'(p / 8), 4'h5, 8'(p % 8)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int h0 = p0 % 8, v0 = p0 / 8, h2 = p2 % 8, v2 = p2 / 8;
    bit req = r0 && h0 < 4 && v0 < 3;
    bit ov = r1 && r2;
    bit dv = ov && h2 < 4 && v2 < 3;
    chk("req", 32'(O_PIXEL_REQUEST), 32'(req));
    chk("col", 32'(O_REQUEST_COLUMN), req ? h0 : 0);
    chk("row", 32'(O_REQUEST_ROW), req ? v0 : 0);
    chk("dv", 32'(O_DATA_VALID), 32'(dv));
    chk("pixel", 32'(O_PIXEL), dv ? 32'(pat(p2)) : 0);
    chk("hsync", 32'(O_HSYNC), 32'(!(ov && h2 >= 5 && h2 < 7)));
    chk("vsync", 32'(O_VSYNC), 32'(!(ov && v2 == 4)));
    chk("fstart", 32'(O_FRAME_START), 32'(ov && p2 == 0));
  endtask
  task automatic step(input bit ce, input bit en, input bit rs);
    logic [23:0] src;
    I_PIXEL_CLK_EN = ce;
    I_ENABLE = en;
    I_RESET = rs;
    @(posedge I_CLK);
    #1;
    if (rs) begin
      r0 = 0; r1 = 0; r2 = 0; p0 = 0; p1 = 0; p2 = 0;
    end else if (ce) begin
      src = (r0 && p0 % 8 < 4 && p0 / 8 < 3) ? pat(p0) : 24'($urandom);
      r2 = r1; p2 = p1; r1 = r0; p1 = p0;
      p0 = (en && r0) ? (p0 + 1) % 48 : 0;
      r0 = en;
      I_PIXEL = src;
    end
    check_all();
  endtask
  initial begin
    int vs_lo, hs_lo, fs_n, dv_n, first, second;
    bit prev_fs, found;
    r0 = 0; r1 = 0; r2 = 0; p0 = 0; p1 = 0; p2 = 0;
    step(0, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("s1_req00", 32'(O_PIXEL_REQUEST), 1);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("s1_fs", 32'(O_FRAME_START), 1);
    chk("s1_pix", 32'(O_PIXEL), 32'(pat(0)));
    repeat (40) step(1, 1, 0);
    vs_lo = 0; hs_lo = 0; fs_n = 0; dv_n = 0;
    repeat (96) begin
      step(1, 1, 0);
      if (!O_VSYNC) vs_lo++;
      if (!O_HSYNC) hs_lo++;
      if (O_FRAME_START) fs_n++;
      if (O_DATA_VALID) dv_n++;
    end
    chk("s3_vsync_ticks", vs_lo, 16);
    chk("s2_hsync_ticks", hs_lo, 24);
    chk("s3_frame_starts", fs_n, 2);
    chk("s2_valid_ticks", dv_n, 24);
    first = -1; second = -1; prev_fs = O_FRAME_START;
    for (int i = 0; i < 330; i++) begin
      step(i % 3 == 0, 1, 0);
      if (O_FRAME_START && !prev_fs) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      prev_fs = O_FRAME_START;
    end
    chk("s4_frame_period", second - first, 144);
    found = 0;
    for (int i = 0; i < 100 && !found; i++)
      if (r0 && p0 == 10) found = 1; else step(1, 1, 0);
    chk("s5_reach_2_1", 32'(found), 1);
    step(1, 0, 0);
    chk("s5_req_low", 32'(O_PIXEL_REQUEST), 0);
    step(1, 0, 0);
    chk("s5_idle_dv", 32'(O_DATA_VALID), 0);
    chk("s5_idle_hs", 32'(O_HSYNC), 1);
    repeat (3) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("s5_restart_fs", 32'(O_FRAME_START), 1);
    repeat (13) step(1, 1, 0);
    step(0, 1, 1);
    chk("s6_rst_req", 32'(O_PIXEL_REQUEST), 0);
    chk("s6_rst_dv", 32'(O_DATA_VALID), 0);
    chk("s6_rst_vs", 32'(O_VSYNC), 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("s6_restart_fs", 32'(O_FRAME_START), 1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(3) != 0, $urandom_range(63) != 0, $urandom_range(199) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
